tx_symbol_serializer: RTL and testbench

Per-lane transmit serializer that sits directly downstream of each lane's 8b10b encoder in the multi-lane transmit path. It accepts 10-bit encoded symbols over a valid/ready handshake and emits them one bit per clock, with a one-symbol holding buffer so back-to-back symbols leave the lane with no gap. It flags underruns when the encoder fails to supply the next symbol in time, and flushes cleanly when the lane is disabled.

---
 rtl/pcie_phy_pkg.sv | 12 +
 rtl/tx_symbol_serializer.sv | 122 ++++++++++++
 tb/tb_tx_symbol_serializer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PHY-layer constants and types for the multi-lane transmit path.
package pcie_phy_pkg;

  localparam int SYMBOL_WIDTH_8B10B = 10;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;

  // Comma symbols in both running disparities.
  localparam logic [9:0] K28_5_RDN = 10'b0101111100;
  localparam logic [9:0] K28_5_RDP = 10'b1010000011;

endpackage

// File: rtl/tx_symbol_serializer.sv
// Per-lane 10b symbol serializer: one-symbol holding buffer ahead of a shift
// register so back-to-back symbols leave the lane without a gap.
module tx_symbol_serializer
  import pcie_phy_pkg::*;
#(
  parameter int SYMBOL_WIDTH = SYMBOL_WIDTH_8B10B,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    lane_enable_i,
  input  logic [SYMBOL_WIDTH-1:0] symbol_i,
  input  logic                    symbol_valid_i,
  output logic                    symbol_ready_o,
  output logic                    bit_o,
  output logic                    bit_valid_o,
  output logic                    symbol_start_o,
  output logic                    underrun_o
);

  localparam int CNT_W = (SYMBOL_WIDTH > 2) ? $clog2(SYMBOL_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYMBOL_WIDTH - 1);

  ser_state_e              state_q, state_d;
  logic [SYMBOL_WIDTH-1:0] hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [SYMBOL_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    underrun_q, underrun_d;
  logic                    active_q;
  logic [SYMBOL_WIDTH-1:0] shift_step;
  logic                    head_bit;
  logic                    accept;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shift_step = {1'b0, shift_q[SYMBOL_WIDTH-1:1]};
      assign head_bit   = shift_q[0];
    end else begin : g_msb_first
      assign shift_step = {shift_q[SYMBOL_WIDTH-2:0], 1'b0};
      assign head_bit   = shift_q[SYMBOL_WIDTH-1];
    end
  endgenerate

  // active_q keeps ready low until the first edge after reset release.
  assign symbol_ready_o = lane_enable_i && active_q && !hold_valid_q;
  assign accept         = symbol_valid_i && symbol_ready_o;
  assign bit_valid_o    = (state_q == SER_SHIFT);
  assign bit_o          = bit_valid_o && head_bit;
  assign symbol_start_o = bit_valid_o && (bit_cnt_q == '0);
  assign underrun_o     = underrun_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= SER_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      underrun_q   <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      underrun_q   <= underrun_d;
      active_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    underrun_d   = 1'b0;

    if (!lane_enable_i) begin
      // Flush: partial symbol and queued symbol are both dropped silently.
      state_d      = SER_IDLE;
      hold_valid_d = 1'b0;
      bit_cnt_d    = '0;
    end else begin
      // Accept only happens with the buffer empty, load only with it full,
      // so the two never fight over hold_valid_d.
      if (accept) begin
        hold_d       = symbol_i;
        hold_valid_d = 1'b1;
      end
      case (state_q)
        SER_IDLE: begin
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            bit_cnt_d    = '0;
            state_d      = SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (hold_valid_q) begin
              shift_d      = hold_q;
              hold_valid_d = 1'b0;
            end else begin
              state_d    = SER_IDLE;
              underrun_d = 1'b1;
            end
          end else begin
            shift_d   = shift_step;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = SER_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_symbol_serializer.sv
// Directed bench for tx_symbol_serializer: LSB-first and MSB-first instances.
module tb_tx_symbol_serializer;
  import pcie_phy_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_l, valid_l, ready_l, bit_l, bv_l, start_l, ur_l;
  logic [9:0] sym_l;
  logic       en_m, valid_m, ready_m, bit_m, bv_m, start_m, ur_m;
  logic [9:0] sym_m;

  int tests    = 0;
  int failures = 0;

  logic tr_v[64];
  logic tr_b[64];
  logic tr_s[64];
  logic tr_u[64];
  logic tr_r[64];

  tx_symbol_serializer #(.SYMBOL_WIDTH(10), .LSB_FIRST(1'b1)) dut_l (
    .clk_i(clk), .rst_i(rst_n), .lane_enable_i(en_l), .symbol_i(sym_l),
    .symbol_valid_i(valid_l), .symbol_ready_o(ready_l), .bit_o(bit_l),
    .bit_valid_o(bv_l), .symbol_start_o(start_l), .underrun_o(ur_l)
  );

  tx_symbol_serializer #(.SYMBOL_WIDTH(10), .LSB_FIRST(1'b0)) dut_m (
    .clk_i(clk), .rst_i(rst_n), .lane_enable_i(en_m), .symbol_i(sym_m),
    .symbol_valid_i(valid_m), .symbol_ready_o(ready_m), .bit_o(bit_m),
    .bit_valid_o(bv_m), .symbol_start_o(start_m), .underrun_o(ur_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offers up to n symbols in order (symbol 1 held back until cycle t1),
  // honouring ready, and records the selected DUT's outputs per cycle.
  task automatic stream(input bit sel, input logic [9:0] s0, input logic [9:0] s1,
                        input logic [9:0] s2, input int n, input int t1,
                        input int cycles, output int n_acc);
    logic [9:0] syms[3];
    int         idx;
    logic       offer;
    logic       acc;
    syms  = '{s0, s1, s2};
    idx   = 0;
    n_acc = 0;
    for (int c = 0; c < cycles; c++) begin
      offer = (idx < n) && !(idx == 1 && c < t1);
      if (sel) begin
        valid_m = offer;
        sym_m   = offer ? syms[idx] : 10'h0;
        tr_v[c] = bv_m; tr_b[c] = bit_m; tr_s[c] = start_m;
        tr_u[c] = ur_m; tr_r[c] = ready_m;
        acc     = offer && ready_m;
      end else begin
        valid_l = offer;
        sym_l   = offer ? syms[idx] : 10'h0;
        tr_v[c] = bv_l; tr_b[c] = bit_l; tr_s[c] = start_l;
        tr_u[c] = ur_l; tr_r[c] = ready_l;
        acc     = offer && ready_l;
      end
      tick();
      if (acc) begin
        idx++;
        n_acc++;
      end
    end
    valid_l = 1'b0;
    valid_m = 1'b0;
  endtask

  // One contiguous burst of nbits starting at cycle 'first', symbols every
  // 10 bits, one underrun right after the burst.
  task automatic check_trace(input string tag, input logic [29:0] exp_bits,
                             input int nbits, input int first, input int cycles);
    logic ev;
    for (int c = 0; c < cycles; c++) begin
      ev = (c >= first) && (c < first + nbits);
      chk($sformatf("%s_valid_c%0d", tag, c), tr_v[c], ev);
      chk($sformatf("%s_start_c%0d", tag, c), tr_s[c], ev && ((c - first) % 10 == 0));
      chk($sformatf("%s_underrun_c%0d", tag, c), tr_u[c], (c == first + nbits));
      if (ev)
        chk($sformatf("%s_bit_c%0d", tag, c), tr_b[c], exp_bits[c - first]);
      else
        chk($sformatf("%s_idlebit_c%0d", tag, c), tr_b[c], 1'b0);
    end
  endtask

  initial begin
    int         n_acc;
    logic [9:0] sa;
    logic [9:0] sb;
    logic       ev;
    logic       eb;

    rst_n = 1'b0;
    en_l = 1'b1; valid_l = 1'b0; sym_l = 10'h0;
    en_m = 1'b1; valid_m = 1'b0; sym_m = 10'h0;

    // Reset state, lane already enabled.
    #2;
    chk("rst_ready", ready_l, 1'b0);
    chk("rst_bit", bit_l, 1'b0);
    chk("rst_bit_valid", bv_l, 1'b0);
    chk("rst_start", start_l, 1'b0);
    chk("rst_underrun", ur_l, 1'b0);
    tick();
    tick();
    chk("rst_hold_ready", ready_l, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", ready_l, 1'b1);
    chk("post_rst_bit_valid", bv_l, 1'b0);
    $display("[TB] reset checks done");

    // Single K28.5 RD-: bits 0,0,1,1,1,1,1,0,1,0 at acceptance+2.
    stream(1'b0, K28_5_RDN, 10'h0, 10'h0, 1, 0, 16, n_acc);
    chk_int("single_accepts", n_acc, 1);
    check_trace("single", {20'b0, 10'b0101111100}, 10, 2, 16);
    $display("[TB] single symbol 0x%03h done", K28_5_RDN);

    // Three symbols back-to-back with valid held high: gapless 30 bits.
    stream(1'b0, 10'h17C, 10'h283, 10'h0F0, 3, 0, 36, n_acc);
    chk_int("b2b_accepts", n_acc, 3);
    chk("b2b_ready_full", tr_r[1], 1'b0);
    chk("b2b_ready_full2", tr_r[5], 1'b0);
    check_trace("b2b", {10'h0F0, 10'h283, 10'h17C}, 30, 2, 36);
    $display("[TB] back-to-back 0x17C 0x283 0x0F0 done");

    // Successor accepted on the final bit: underrun, one idle cycle, restart.
    stream(1'b0, K28_5_RDP, 10'h17C, 10'h0, 2, 11, 28, n_acc);
    chk_int("late_accepts", n_acc, 2);
    sa = K28_5_RDP;
    sb = 10'h17C;
    for (int c = 0; c < 28; c++) begin
      ev = (c >= 2 && c <= 11) || (c >= 13 && c <= 22);
      eb = (c >= 2 && c <= 11) ? sa[c - 2] : ((c >= 13 && c <= 22) ? sb[c - 13] : 1'b0);
      chk($sformatf("late_valid_c%0d", c), tr_v[c], ev);
      chk($sformatf("late_bit_c%0d", c), tr_b[c], eb);
      chk($sformatf("late_start_c%0d", c), tr_s[c], (c == 2) || (c == 13));
      chk($sformatf("late_underrun_c%0d", c), tr_u[c], (c == 12) || (c == 23));
    end
    $display("[TB] late successor done");

    // Disable mid-symbol with a symbol queued.
    valid_l = 1'b1;
    sym_l   = K28_5_RDP;
    chk("dis_ready0", ready_l, 1'b1);
    tick();
    sym_l = 10'h17C;
    tick();
    chk("dis_start", start_l, 1'b1);
    chk("dis_ready_refill", ready_l, 1'b1);
    tick();
    valid_l = 1'b0;
    chk("dis_ready_full", ready_l, 1'b0);
    repeat (3) tick();
    chk("dis_bit4_valid", bv_l, 1'b1);
    chk("dis_bit4", bit_l, 1'b0);
    en_l = 1'b0;
    tick();
    chk("dis_valid", bv_l, 1'b0);
    chk("dis_bit", bit_l, 1'b0);
    chk("dis_ready", ready_l, 1'b0);
    chk("dis_underrun", ur_l, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("dis_hold_valid_%0d", i), bv_l, 1'b0);
      chk($sformatf("dis_hold_underrun_%0d", i), ur_l, 1'b0);
    end
    en_l = 1'b1;
    #1;
    chk("reen_ready", ready_l, 1'b1);
    tick();
    stream(1'b0, 10'h283, 10'h0, 10'h0, 1, 0, 16, n_acc);
    chk_int("reen_accepts", n_acc, 1);
    check_trace("reen", {20'b0, 10'h283}, 10, 2, 16);
    $display("[TB] disable/re-enable done");

    // Reset asserted during bit 6.
    valid_l = 1'b1;
    sym_l   = K28_5_RDN;
    tick();
    valid_l = 1'b0;
    tick();
    repeat (6) tick();
    chk("prerst_valid", bv_l, 1'b1);
    chk("prerst_bit6", bit_l, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bv_l, 1'b0);
    chk("midrst_bit", bit_l, 1'b0);
    chk("midrst_start", start_l, 1'b0);
    chk("midrst_underrun", ur_l, 1'b0);
    chk("midrst_ready", ready_l, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_release_ready", ready_l, 1'b1);
    stream(1'b0, 10'h0F0, 10'h0, 10'h0, 1, 0, 16, n_acc);
    chk_int("postrst_accepts", n_acc, 1);
    check_trace("postrst", {20'b0, 10'h0F0}, 10, 2, 16);
    $display("[TB] mid-symbol reset done");

    // MSB-first instance: 10'b1100000000 -> 1,1,0,0,0,0,0,0,0,0.
    stream(1'b1, 10'b1100000000, 10'h0, 10'h0, 1, 0, 16, n_acc);
    chk_int("msb_accepts", n_acc, 1);
    check_trace("msb", {20'b0, 10'b0000000011}, 10, 2, 16);
    $display("[TB] msb-first done");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
